layer2_conv_sched: RTL
======================

LAYER2_CONV_SCHED -- requirements
Module: layer2_conv_sched

Interface
REQ-001 SHALL have parameter COLS, default 14, meaning output feature-map width in pixels.
REQ-002 SHALL have parameter ROWS, default 14, meaning output feature-map height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning input-buffer address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a frame.
REQ-007 SHALL have port busy, output, 1, high from frame start until done.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse at frame end.
REQ-009 SHALL have port rd_en, output, 1, input/weight buffer read strobe.
REQ-010 SHALL have port in_addr, output, ADDR_W, input-buffer address for padded 8-channel pixel vectors.
REQ-011 SHALL have port w_addr, output, 4, weight tap index 0..8 selecting weight1..weight8 set.
REQ-012 SHALL have ports psum1..psum8, input, 16 each, signed per-output-channel results from the 8x8 MAC array.
REQ-013 SHALL have port bias, input, 128, eight signed 16-bit biases; channel1 in [127:112]; static while busy.
REQ-014 SHALL have port out_data, output, 128, eight signed 16-bit results; channel1 in [127:112].
REQ-015 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.

Function
REQ-016 SHALL implement states IDLE, FETCH, LAST, OUT.
REQ-017 IDLE: start=1 -> FETCH; row=0, col=0, tap=0, busy=1 next cycle.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 FETCH: rd_en=1, w_addr=tap, in_addr=(row+tap/3)*(COLS+2)+(col+tap%3); tap increments each cycle; at tap=8 -> LAST.
REQ-020 Buffer read plus MAC array latency is fixed at 1 cycle: psum for tap t is sampled the cycle after rd_en for tap t.
REQ-021 Accumulator per channel: on the sample of tap 0, acc = sat(bias_ch + psum_ch); on taps 1..8, acc = sat(acc + psum_ch).
REQ-022 sat(): 17-bit signed sum clamped to [-32768, 32767].
REQ-023 LAST: rd_en=0; samples tap-8 psum; -> OUT.
REQ-024 OUT: out_valid=1; out_data channel = ReLU(acc), negative -> 0; out_data stable while out_valid=1 and out_ready=0.
REQ-025 Handshake completes when out_valid and out_ready are both 1; out_valid falls the next cycle unless a new result is presented.
REQ-026 On handshake in OUT, if col<COLS-1: col+1, else col=0, row+1; tap=0; -> FETCH.
REQ-027 On handshake with row=ROWS-1 and col=COLS-1: -> IDLE; done=1 for that next cycle; busy=0.
REQ-028 Pixel period SHALL be 11 cycles when out_ready is held high (9 FETCH + 1 LAST + 1 OUT).
REQ-029 Pixels SHALL be emitted in raster order, row-major.
REQ-030 rd_en SHALL be 0 outside FETCH; in_addr and w_addr SHALL be 0 when rd_en=0.

Reset
REQ-031 rst=1 SHALL force IDLE at the next edge from any state, including mid-FETCH or mid-OUT.
REQ-032 Reset values: busy=0, done=0, rd_en=0, in_addr=0, w_addr=0, out_valid=0, out_data=0, all accumulators=0, row=col=tap=0.
REQ-033 rst SHALL take priority over start and over out_ready.

Verification
REQ-034 COLS=ROWS=2, start pulse, out_ready=1 -> rd_en in 9 consecutive cycles; pixel(0,0) in_addr sequence 0,1,2,4,5,6,8,9,10; out_valid every 11 cycles; 4 results; done pulse once.
REQ-035 All psum=0x0100, bias=0 -> every channel of out_data = 0x0900; with bias ch1=0x0010 -> ch1 = 0x0910.
REQ-036 psum ch1=0x7000 every tap -> ch1 saturates to 0x7FFF; psum ch2=0x9000 every tap -> ch2 = 0x0000 after ReLU.
REQ-037 out_ready=0 for 5 cycles in OUT -> out_valid held 1, out_data unchanged, no rd_en; proceeds 1 cycle after out_ready=1.
REQ-038 rst=1 asserted at FETCH tap 4 -> next cycle all outputs at reset values; new start restarts at pixel(0,0), tap 0.
REQ-039 start pulsed while busy -> no effect on sequence, result count, or done timing.

Source files
------------

// File: rtl/layer2_conv_sched.sv
// Layer-2 3x3 convolution scheduler: walks the 9 taps of each output pixel in raster
// order, accumulates the 8 MAC-array channel results with bias, saturation and ReLU.
`timescale 1ns/1ps

module layer2_conv_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        smp,
  input  logic        first,
  input  logic [15:0] bias,
  input  logic [15:0] psum,
  output logic [15:0] res
);
  logic [15:0] r_acc;
  logic [15:0] w_base;
  logic [16:0] w_sum;
  logic [15:0] w_sat;

  always_comb begin
    w_base = first ? bias : r_acc;
    w_sum  = {w_base[15], w_base} + {psum[15], psum};
    // 17-bit sum overflowed 16 bits when its top two bits disagree
    if (w_sum[16] != w_sum[15]) w_sat = w_sum[16] ? 16'h8000 : 16'h7FFF;
    else                        w_sat = w_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst)      r_acc <= '0;
    else if (smp) r_acc <= w_sat;
  end

  assign res = r_acc[15] ? 16'h0000 : r_acc;
endmodule

module layer2_conv_sched #(
  parameter int COLS   = 14,
  parameter int ROWS   = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [3:0]        w_addr,
  input  logic [15:0]       psum1,
  input  logic [15:0]       psum2,
  input  logic [15:0]       psum3,
  input  logic [15:0]       psum4,
  input  logic [15:0]       psum5,
  input  logic [15:0]       psum6,
  input  logic [15:0]       psum7,
  input  logic [15:0]       psum8,
  input  logic [127:0]      bias,
  output logic [127:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int NUM_LANES = 8;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, OUT} state_t;

  state_t          r_state, w_next;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [3:0]      r_tap;
  logic            r_done;
  logic            r_smp;
  logic            r_first;
  logic            w_hs;
  logic            w_last_pix;
  logic [1:0]      w_kr, w_kc;

  logic [NUM_LANES-1:0][15:0] w_psum;
  logic [NUM_LANES-1:0][15:0] w_bias;
  logic [NUM_LANES-1:0][15:0] w_res;

  // lane 7 is channel 1 so the packed vectors line up with bias/out_data
  assign w_psum = {psum1, psum2, psum3, psum4, psum5, psum6, psum7, psum8};
  assign w_bias = bias;

  assign w_hs       = (r_state == OUT) && out_ready;
  assign w_last_pix = (r_row == RW'(ROWS-1)) && (r_col == CW'(COLS-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   if (r_tap == 4'd8) w_next = LAST;
      LAST:    w_next = OUT;
      OUT:     if (w_hs) w_next = w_last_pix ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_tap   <= '0;
      r_done  <= 1'b0;
      r_smp   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_done  <= w_hs && w_last_pix;
      // MAC latency is one cycle: sample the tap issued last cycle
      r_smp   <= (r_state == FETCH);
      r_first <= (r_state == FETCH) && (r_tap == 4'd0);
      case (r_state)
        IDLE: if (start) begin
          r_row <= '0;
          r_col <= '0;
          r_tap <= '0;
        end
        FETCH: if (r_tap != 4'd8) r_tap <= r_tap + 4'd1;
        OUT: if (w_hs) begin
          r_tap <= '0;
          if (r_col == CW'(COLS-1)) begin
            r_col <= '0;
            r_row <= w_last_pix ? '0 : r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_tap)
      4'd0, 4'd1, 4'd2: w_kr = 2'd0;
      4'd3, 4'd4, 4'd5: w_kr = 2'd1;
      default:          w_kr = 2'd2;
    endcase
    case (r_tap)
      4'd0, 4'd3, 4'd6: w_kc = 2'd0;
      4'd1, 4'd4, 4'd7: w_kc = 2'd1;
      default:          w_kc = 2'd2;
    endcase
  end

  assign rd_en   = (r_state == FETCH);
  assign w_addr  = rd_en ? r_tap : 4'd0;
  assign in_addr = rd_en ? (ADDR_W'(r_row) + ADDR_W'(w_kr)) * ADDR_W'(COLS+2)
                           + ADDR_W'(r_col) + ADDR_W'(w_kc)
                         : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    layer2_conv_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .smp   (r_smp),
      .first (r_first),
      .bias  (w_bias[g]),
      .psum  (w_psum[g]),
      .res   (w_res[g])
    );
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign out_valid = (r_state == OUT);
  assign out_data  = out_valid ? w_res : '0;
endmodule
